apb_regfile_ws: RTL and testbench
=================================

# apb_regfile_ws

Parametrised APB4 register-file slave: N_REGS registers of DATA_W bits, byte-strobed writes, programmable wait states, per-register read-only mask and error response. Sits between the APB bridge and block-level control logic; registers are exported as a flat bus and can also be loaded from hardware. It is the general-purpose successor to our fixed seven-register APB slave.

## Interface
Parameters:
- ADDR_W, 4: width of PADDR, a word index, not a byte address; 2**ADDR_W >= N_REGS.
- DATA_W, 32: register and bus width; a multiple of 8.
- N_REGS, 8: number of implemented registers, 1..2**ADDR_W.
- WAIT_CYCLES, 0: wait states inserted in every access phase, 0..15.
- RO_MASK, {N_REGS{1'b0}}: bit i set means register i is read-only from APB.

Ports:
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  register index.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte write strobes. Ignored on reads.
- PREADY  out  1  transfer-complete indicator.
- PRDATA  out  DATA_W  read data.
- PSLVERR  out  1  error response.
- reg_q  out  N_REGS*DATA_W  register contents. Register i occupies [i*DATA_W +: DATA_W].
- hw_we  in  N_REGS  hardware load enable, one bit per register.
- hw_wdata  in  N_REGS*DATA_W  hardware load data, same packing as reg_q.
- wr_pulse  out  N_REGS  one-cycle pulse when an APB write commits to register i.

## Operation
FSM states: IDLE and ACCESS. Reset state is IDLE.
- IDLE to ACCESS: on a setup phase (PSEL=1, PENABLE=0). On the same edge:
  - wait counter loads WAIT_CYCLES.
  - err_q latches (PADDR >= N_REGS) | (PWRITE & RO_MASK[PADDR]).
  - On reads, PRDATA loads reg_q[PADDR], or 0 if the address is out of range. This is snapshot semantics.
- In ACCESS:
  - PREADY = (cnt == 0).
  - While PSEL & PENABLE & cnt != 0: cnt decrements by 1 per cycle.
- Completion: an edge with PSEL & PENABLE & PREADY in ACCESS.
  - A write without error updates the strobed bytes of register PADDR and pulses wr_pulse[PADDR] in the next cycle.
  - Next state is IDLE. Back-to-back transfers require a new setup phase, per APB.
- PSLVERR = ACCESS & PREADY & err_q. 0 at all other times.
- Error transfers:
  - No register changes and no wr_pulse.
  - A read error returns PRDATA = 0.
- Abort: if PSEL drops in ACCESS before completion, return to IDLE. No write, no pulse.
- Hardware load: when hw_we[i]=1, register i loads its hw_wdata slice at the next edge. RO registers change only through this path.
- Same-cycle conflict on one register: the APB write wins for bytes whose strobe is set; hw_wdata supplies the remaining bytes.
- A write with PSTRB = 0 completes without error, changes nothing, and still pulses wr_pulse.

## Timing
- Reset values: PREADY=1, PRDATA=0, PSLVERR=0, all registers 0, wr_pulse=0, state IDLE, cnt 0.
- PREADY = 1 in IDLE.
- Latency: the access phase lasts WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, a transfer is setup + 1 access cycle, zero-wait.
- PREADY and PSLVERR are decoded from registered state only; no input-to-output combinational path.
- PRDATA is stable from the first access cycle until the next read setup.
- reg_q updates on the edge that completes the transfer.
- rst_n assertion mid-transfer immediately forces all reset values. The in-flight write is lost.

## Structure
- Package apb_regfile_pkg holds:
  - state enum {ST_IDLE, ST_ACCESS}.
  - wait-counter width constant (4 bits).
  - function strb_w(DATA_W) = DATA_W/8.
- Sub-module apb_strb_reg: one DATA_W register with per-byte merge of APB strobe data and hardware load data, and an async reset to 0. It is instantiated N_REGS times in a generate loop; the top holds the FSM, wait counter, decode and read mux.

## Test plan
- Zero-wait write/read: WAIT_CYCLES=0. Write 0xDEADBEEF to reg 2 with PSTRB=4'hF, then read reg 2 → PREADY high in the first access cycle, PRDATA=0xDEADBEEF, wr_pulse[2] for one cycle.
- Byte strobes: reg 3 holds 0x11223344. Write 0xAABBCCDD with PSTRB=4'b0101 → reg 3 = 0x11BB33DD.
- Wait states: WAIT_CYCLES=3 → PREADY low for 3 access cycles, high on the 4th; write commits only on that edge.
- Errors, with N_REGS=6 and RO_MASK[1]=1:
  - read index 7 → PSLVERR=1, PRDATA=0.
  - write reg 1 → PSLVERR=1, reg unchanged, no pulse.
- Conflict and abort:
  - hw_we[0] with 0x0000FFFF on the same edge as an APB write of 0x12345678 with PSTRB=4'b1100 → reg 0 = 0x1234FFFF.
  - PSEL drop mid-wait → no write.
- Reset mid-transfer: assert rst_n low during a waited write → all outputs at reset values immediately, register not written.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// Shared definitions for the APB register file.
// Contents: transfer FSM state type, wait-counter width, and the strobe-width
// helper used to size PSTRB from the data width.
package apb_regfile_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_e;

    // Wide enough for the maximum of 15 wait states.
    localparam int unsigned CNT_W = 4;

    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_strb_reg.sv
// One register with per-byte merge of APB write data and hardware load data.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (register clears to 0)
//   apb_we_i        APB write commits this cycle
//   apb_strb_i      byte strobes for the APB write
//   apb_wdata_i     APB write data
//   hw_we_i         hardware load enable
//   hw_wdata_i      hardware load data
//   q_o             register contents
module apb_strb_reg
    import apb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = strb_w(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              apb_we_i,
    input  logic [STRB_W-1:0] apb_strb_i,
    input  logic [DATA_W-1:0] apb_wdata_i,
    input  logic              hw_we_i,
    input  logic [DATA_W-1:0] hw_wdata_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;

    // APB owns strobed bytes; hardware load fills every byte APB does not touch.
    always_comb begin
        q_d = q_q;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (apb_we_i && apb_strb_i[b]) begin
                q_d[b*8 +: 8] = apb_wdata_i[b*8 +: 8];
            end else if (hw_we_i) begin
                q_d[b*8 +: 8] = hw_wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/apb_regfile_ws.sv
// APB4 register-file slave with byte strobes, programmable wait states,
// per-register read-only mask, error response and hardware load path.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   PSEL..PSTRB       APB request (PADDR is a word index)
//   PREADY, PRDATA,
//   PSLVERR           APB response, all decoded from registered state
//   reg_q             flat register export, register i at [i*DATA_W +: DATA_W]
//   hw_we, hw_wdata   hardware load enable / data, same packing as reg_q
//   wr_pulse          one-cycle pulse in the cycle after an APB write commits
module apb_regfile_ws
    import apb_regfile_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned N_REGS      = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [N_REGS-1:0] RO_MASK = {N_REGS{1'b0}},
    localparam int unsigned STRB_W     = strb_w(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [ADDR_W-1:0]        PADDR,
    input  logic [DATA_W-1:0]        PWDATA,
    input  logic [STRB_W-1:0]        PSTRB,
    output logic                     PREADY,
    output logic [DATA_W-1:0]        PRDATA,
    output logic                     PSLVERR,
    output logic [N_REGS*DATA_W-1:0] reg_q,
    input  logic [N_REGS-1:0]        hw_we,
    input  logic [N_REGS*DATA_W-1:0] hw_wdata,
    output logic [N_REGS-1:0]        wr_pulse
);

    state_e             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               err_d, err_q;
    logic [DATA_W-1:0]  prdata_d, prdata_q;
    logic [N_REGS-1:0]  wr_pulse_d, wr_pulse_q;

    logic               addr_hit;
    logic               ro_hit;
    logic [DATA_W-1:0]  rd_word;
    logic               cnt_zero;
    logic               apb_commit;
    logic [N_REGS-1:0]  wr_sel;

    // Address decode; indices at or above N_REGS match nothing.
    always_comb begin
        addr_hit = 1'b0;
        ro_hit   = 1'b0;
        rd_word  = '0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            if (PADDR == ADDR_W'(i)) begin
                addr_hit = 1'b1;
                ro_hit   = RO_MASK[i];
                rd_word  = reg_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        prdata_d   = prdata_q;
        apb_commit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    err_d   = !addr_hit || (PWRITE && ro_hit);
                    // Read data is captured at setup and held through the access phase.
                    if (!PWRITE) begin
                        prdata_d = addr_hit ? rd_word : '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (PENABLE) begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d    = ST_IDLE;
                        apb_commit = PWRITE && !err_q;
                    end
                end
            end
        endcase
    end

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            wr_sel[i] = apb_commit && (PADDR == ADDR_W'(i));
        end
    end

    assign wr_pulse_d = wr_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign PREADY   = (state_q == ST_IDLE) || cnt_zero;
    assign PSLVERR  = (state_q == ST_ACCESS) && cnt_zero && err_q;
    assign PRDATA   = prdata_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar g = 0; g < int'(N_REGS); g++) begin : g_reg
        apb_strb_reg #(
            .DATA_W(DATA_W)
        ) u_reg (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .apb_we_i   (wr_sel[g]),
            .apb_strb_i (PSTRB),
            .apb_wdata_i(PWDATA),
            .hw_we_i    (hw_we[g]),
            .hw_wdata_i (hw_wdata[g*DATA_W +: DATA_W]),
            .q_o        (reg_q[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_apb_regfile_ws.sv
// Directed bench for apb_regfile_ws. Two instances share one APB bus:
// u_dut0 has no wait states, u_dut3 has three; both have six registers with
// register 1 read-only. use3 selects which instance PSEL reaches and which
// instance's outputs are observed.
module tb_apb_regfile_ws;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          use3 = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic [NR-1:0] hw_we = '0;
    logic [NR*DW-1:0] hw_wdata = '0;

    logic          pready0, pready3, pslverr0, pslverr3;
    logic [DW-1:0] prdata0, prdata3;
    logic [NR*DW-1:0] regq0, regq3;
    logic [NR-1:0] wrp0, wrp3;

    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic [NR*DW-1:0] regq;
    logic [NR-1:0] wr_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_regfile_ws #(
        .ADDR_W(AW), .DATA_W(DW), .N_REGS(NR), .WAIT_CYCLES(0), .RO_MASK(6'b000010)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .PSEL(psel && !use3), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0), .reg_q(regq0),
        .hw_we(hw_we), .hw_wdata(hw_wdata), .wr_pulse(wrp0)
    );

    apb_regfile_ws #(
        .ADDR_W(AW), .DATA_W(DW), .N_REGS(NR), .WAIT_CYCLES(3), .RO_MASK(6'b000010)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .PSEL(psel && use3), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3), .reg_q(regq3),
        .hw_we(hw_we), .hw_wdata(hw_wdata), .wr_pulse(wrp3)
    );

    assign pready   = use3 ? pready3  : pready0;
    assign pslverr  = use3 ? pslverr3 : pslverr0;
    assign prdata   = use3 ? prdata3  : prdata0;
    assign regq     = use3 ? regq3    : regq0;
    assign wr_pulse = use3 ? wrp3     : wrp0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] reg_word(input int k);
        return regq[k*DW +: DW];
    endfunction

    // Drives a setup phase; on return the DUT is in its first access cycle with PENABLE high.
    task automatic apb_setup(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        step();
        penable = 1'b1;
    endtask

    // Holds the access phase until PREADY; waits = -1 if the bound expires.
    task automatic apb_access(output int waits, output logic err, output logic [DW-1:0] rd);
        waits = -1; err = 1'b0; rd = '0;
        for (int n = 0; n < 16; n++) begin
            if (pready === 1'b1) begin
                err = pslverr; rd = prdata; waits = n;
                step();
                break;
            end
            step();
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL rst_pready: got %b want 1", pready); end
        checks++; if (prdata !== '0) begin errors++; $display("FAIL rst_prdata: got %h want 0", prdata); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b want 0", pslverr); end
        checks++; if (regq !== '0) begin errors++; $display("FAIL rst_regs: got %h want 0", regq); end
        checks++; if (wr_pulse !== '0) begin errors++; $display("FAIL rst_pulse: got %b want 0", wr_pulse); end
    endtask

    task automatic test_zero_wait();
        int w; logic e; logic [DW-1:0] r;
        use3 = 1'b0;
        apb_setup(1'b1, 4'd2, 32'hDEADBEEF, 4'hF);
        apb_access(w, e, r);
        checks++; if (w !== 0) begin errors++; $display("FAIL zw_wr_waits: got %0d want 0", w); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL zw_wr_err: got %b want 0", e); end
        checks++; if (wr_pulse !== 6'b000100) begin errors++; $display("FAIL zw_pulse: got %b want 000100", wr_pulse); end
        checks++; if (reg_word(2) !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_reg2: got %h want deadbeef", reg_word(2)); end
        step();
        checks++; if (wr_pulse !== 6'b000000) begin errors++; $display("FAIL zw_pulse_off: got %b want 000000", wr_pulse); end
        apb_setup(1'b0, 4'd2, 32'h0, 4'h0);
        apb_access(w, e, r);
        checks++; if (w !== 0) begin errors++; $display("FAIL zw_rd_waits: got %0d want 0", w); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rd_data: got %h want deadbeef", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL zw_rd_err: got %b want 0", e); end
    endtask

    task automatic test_byte_strobes();
        int w; logic e; logic [DW-1:0] r;
        use3 = 1'b0;
        apb_setup(1'b1, 4'd3, 32'h11223344, 4'hF);
        apb_access(w, e, r);
        apb_setup(1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
        apb_access(w, e, r);
        checks++; if (reg_word(3) !== 32'h11BB33DD) begin errors++; $display("FAIL strb_reg3: got %h want 11bb33dd", reg_word(3)); end
        apb_setup(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000);
        apb_access(w, e, r);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL strb0_err: got %b want 0", e); end
        checks++; if (wr_pulse !== 6'b001000) begin errors++; $display("FAIL strb0_pulse: got %b want 001000", wr_pulse); end
        checks++; if (reg_word(3) !== 32'h11BB33DD) begin errors++; $display("FAIL strb0_reg3: got %h want 11bb33dd", reg_word(3)); end
        step();
    endtask

    task automatic test_wait_states();
        int w; logic e; logic [DW-1:0] r;
        use3 = 1'b1;
        apb_setup(1'b1, 4'd4, 32'hCAFEF00D, 4'hF);
        for (int c = 0; c < 3; c++) begin
            checks++; if (pready !== 1'b0) begin errors++; $display("FAIL ws_pready_low%0d: got %b want 0", c, pready); end
            checks++; if (reg_word(4) !== 32'h0) begin errors++; $display("FAIL ws_early%0d: got %h want 0", c, reg_word(4)); end
            step();
        end
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL ws_pready_high: got %b want 1", pready); end
        checks++; if (reg_word(4) !== 32'h0) begin errors++; $display("FAIL ws_pre_commit: got %h want 0", reg_word(4)); end
        step();
        psel = 1'b0; penable = 1'b0;
        checks++; if (reg_word(4) !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_commit: got %h want cafef00d", reg_word(4)); end
        checks++; if (wr_pulse !== 6'b010000) begin errors++; $display("FAIL ws_pulse: got %b want 010000", wr_pulse); end
        apb_setup(1'b0, 4'd4, 32'h0, 4'h0);
        apb_access(w, e, r);
        checks++; if (w !== 3) begin errors++; $display("FAIL ws_rd_waits: got %0d want 3", w); end
        checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_rd_data: got %h want cafef00d", r); end
    endtask

    task automatic test_errors();
        int w; logic e; logic [DW-1:0] r;
        use3 = 1'b0;
        // PRDATA still holds deadbeef from the earlier read, so a zero here is meaningful.
        apb_setup(1'b0, 4'd7, 32'h0, 4'h0);
        apb_access(w, e, r);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_rd_slverr: got %b want 1", e); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL err_rd_data: got %h want 0", r); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL err_idle_slverr: got %b want 0", pslverr); end
        apb_setup(1'b1, 4'd1, 32'h87654321, 4'hF);
        apb_access(w, e, r);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_ro_slverr: got %b want 1", e); end
        checks++; if (reg_word(1) !== 32'h0) begin errors++; $display("FAIL err_ro_reg: got %h want 0", reg_word(1)); end
        checks++; if (wr_pulse !== 6'b000000) begin errors++; $display("FAIL err_ro_pulse: got %b want 000000", wr_pulse); end
        apb_setup(1'b1, 4'd7, 32'h87654321, 4'hF);
        apb_access(w, e, r);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_oor_slverr: got %b want 1", e); end
        checks++; if (wr_pulse !== 6'b000000) begin errors++; $display("FAIL err_oor_pulse: got %b want 000000", wr_pulse); end
    endtask

    task automatic test_conflict();
        int w; logic e; logic [DW-1:0] r;
        use3 = 1'b0;
        apb_setup(1'b1, 4'd0, 32'h12345678, 4'b1100);
        hw_we = 6'b000001;
        hw_wdata = '0;
        hw_wdata[31:0] = 32'h0000FFFF;
        apb_access(w, e, r);
        hw_we = '0;
        checks++; if (reg_word(0) !== 32'h1234FFFF) begin errors++; $display("FAIL conflict_reg0: got %h want 1234ffff", reg_word(0)); end
        // Hardware path is the only way into a read-only register.
        hw_we = 6'b000010;
        hw_wdata[63:32] = 32'h5A5A5A5A;
        step();
        hw_we = '0;
        checks++; if (reg_word(1) !== 32'h5A5A5A5A) begin errors++; $display("FAIL hw_ro_reg1: got %h want 5a5a5a5a", reg_word(1)); end
        checks++; if (wr_pulse !== 6'b000000) begin errors++; $display("FAIL hw_pulse: got %b want 000000", wr_pulse); end
    endtask

    task automatic test_abort();
        int w; logic e; logic [DW-1:0] r;
        use3 = 1'b1;
        apb_setup(1'b1, 4'd5, 32'h55AA55AA, 4'hF);
        step();
        step();
        psel = 1'b0; penable = 1'b0;
        step();
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL abort_pready: got %b want 1", pready); end
        checks++; if (reg_word(5) !== 32'h0) begin errors++; $display("FAIL abort_reg5: got %h want 0", reg_word(5)); end
        step();
        step();
        checks++; if (reg_word(5) !== 32'h0) begin errors++; $display("FAIL abort_reg5_late: got %h want 0", reg_word(5)); end
        checks++; if (wr_pulse !== 6'b000000) begin errors++; $display("FAIL abort_pulse: got %b want 000000", wr_pulse); end
        apb_setup(1'b1, 4'd5, 32'h0F0F0F0F, 4'hF);
        apb_access(w, e, r);
        checks++; if (w !== 3) begin errors++; $display("FAIL post_abort_waits: got %0d want 3", w); end
        checks++; if (reg_word(5) !== 32'h0F0F0F0F) begin errors++; $display("FAIL post_abort_reg5: got %h want 0f0f0f0f", reg_word(5)); end
    endtask

    task automatic test_reset_mid();
        use3 = 1'b1;
        apb_setup(1'b1, 4'd4, 32'h01010101, 4'hF);
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL rmid_pready: got %b want 1", pready); end
        checks++; if (prdata !== '0) begin errors++; $display("FAIL rmid_prdata: got %h want 0", prdata); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL rmid_pslverr: got %b want 0", pslverr); end
        checks++; if (regq !== '0) begin errors++; $display("FAIL rmid_regs: got %h want 0", regq); end
        checks++; if (wr_pulse !== '0) begin errors++; $display("FAIL rmid_pulse: got %b want 0", wr_pulse); end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++; if (reg_word(4) !== 32'h0) begin errors++; $display("FAIL rmid_reg4: got %h want 0", reg_word(4)); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_zero_wait();
        test_byte_strobes();
        test_wait_states();
        test_errors();
        test_conflict();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
